prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Top-level run controller between the bench/host `req`/`ack` handshake and the single-cycle core.
- Each `req` pulse launches the next program in round-robin order (1, 2, 3, 1, ...):
  - loads that program's start PC;
  - enables the core;
  - waits for the core's halt;
  - raises `ack`.
- Also provides a per-run cycle counter and a watchdog, so a hung program still returns `ack`, with the fault flagged.

Parameters:
- PC_W, 10, width of the program counter / start addresses.
- START1, 10'd0, start PC of program 1.
- START2, 10'd256, start PC of program 2.
- START3, 10'd512, start PC of program 3.
- CNT_W, 16, width of the cycle counter.
- TIMEOUT, 16'd60000, run cycles before watchdog fault; must be < 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  start request from bench; level, acted on at its rising edge.
- halt  input  1  core has executed its halt instruction; level.
- ack  output  1  program finished (or faulted); held until next accepted req.
- pc_load  output  1  one-cycle strobe; core loads `start_pc` into its PC and clears its halt flag.
- start_pc  output  PC_W  start address for the current program; valid while pc_load=1.
- run_en  output  1  core advances its PC and commits state only when 1.
- prog_id  output  2  current/last program launched: 1, 2 or 3 (0 after reset).
- cycle_cnt  output  CNT_W  RUN cycles of the current/last run; saturating.
- fault  output  1  last run ended by watchdog, not by halt.

Behaviour:
- Reset (synchronous, dominates all other inputs):
  - state=IDLE;
  - ack=0, pc_load=0, run_en=0, prog_id=0, cycle_cnt=0, fault=0;
  - req edge register=0;
  - next program = 1.
- Reset asserted mid-RUN: run_en drops the following cycle and no ack is produced.
- Rising edge of req: req_q stores last req, and rise = req & ~req_q.
  - A req held high for many cycles counts as one request.
  - A rise seen while state is LOAD or RUN is ignored; it is not queued.
- States:
  - IDLE:
    - rise -> LOAD.
  - LOAD (exactly 1 cycle):
    - pc_load=1, start_pc=START[next];
    - prog_id<=next, next advances 1->2->3->1;
    - cycle_cnt<=0, fault<=0;
    - -> RUN.
  - RUN:
    - run_en=1, and cycle_cnt increments each cycle, saturating at all-ones.
    - halt=1 -> DONE. The halting cycle is counted.
    - cycle_cnt reaching TIMEOUT with halt=0 -> DONE with fault<=1.
    - If halt and timeout coincide, halt wins and fault=0.
  - DONE:
    - run_en=0, ack=1; ack is held.
    - rise -> LOAD, with ack=0 in that same LOAD cycle.
    - req high continuously since launch does not relaunch; a new rising edge is required.
- Latency:
  - req rise at cycle t -> pc_load at t+1 -> run_en at t+2 -> halt at cycle h -> ack at h+1.
- halt is sampled only in RUN. A stale halt from the previous program is cleared by pc_load, and is not sampled during LOAD.
- After DONE, cycle_cnt and fault hold their values until the next LOAD.
- Outputs ack, run_en and pc_load are decoded from registered state (Moore); there are no combinational paths from req or halt to outputs.

Decomposition:
- Package prog_seq_pkg holds:
  - typedef enum logic[1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;
  - typedef logic[1:0] prog_id_t;
  - function next_prog(prog_id_t), returning 1->2->3->1, with 0 mapped to 1.
- Start-address parameters stay on the module so the top can override them.
- One sub-module, seq_cycle_ctr:
  - CNT_W-bit saturating counter with clr, en and tc (count==TIMEOUT) outputs;
  - reused later for instruction-count statistics.

Test Plan:
- Reset held 3 cycles, then released -> ack=0, run_en=0, prog_id=0, cycle_cnt=0, fault=0; no pc_load for 20 idle cycles.
- req pulse 1 cycle, halt model asserts 50 cycles after pc_load -> pc_load=1 with start_pc=0 one cycle after the rise; ack=1 with prog_id=1, cycle_cnt=50, fault=0.
- Three sequential req/halt runs, then a fourth -> start_pc sequence 0, 256, 512, 0; prog_id 1, 2, 3, 1; ack drops in each LOAD cycle.
- req held high 200 cycles across the whole run, plus an extra req pulse while in RUN -> exactly one launch, no relaunch after DONE until a fresh rise.
- halt never asserted, TIMEOUT overridden to 100 -> ack=1, fault=1, cycle_cnt=100, run_en=0; the next req clears fault in LOAD.
- Synchronous reset asserted 10 cycles into RUN -> run_en=0 and state IDLE the next cycle, ack stays 0, and the next req launches program 1 again.

Source files
------------

// File: rtl/prog_sequencer_pkg.sv
// Shared types for the program run sequencer: FSM states, program ids and
// the round-robin program selection helper.
package prog_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

  typedef logic [1:0] prog_id_t;

  // Round-robin 1 -> 2 -> 3 -> 1; the post-reset value 0 starts at program 1.
  function automatic prog_id_t next_prog(input prog_id_t id);
    case (id)
      2'd1:    return 2'd2;
      2'd2:    return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Host/core-facing signal bundle of the sequencer. The slave side is the
// sequencer itself; the master side is the host plus core that surround it.
interface prog_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  import prog_seq_pkg::*;

  logic             req;
  logic             halt;
  logic             ack;
  logic             pc_load;
  logic [PC_W-1:0]  start_pc;
  logic             run_en;
  prog_id_t         prog_id;
  logic [CNT_W-1:0] cycle_cnt;
  logic             fault;

  modport master (
    output req, halt,
    input  ack, pc_load, start_pc, run_en, prog_id, cycle_cnt, fault
  );

  modport slave (
    input  req, halt,
    output ack, pc_load, start_pc, run_en, prog_id, cycle_cnt, fault
  );

endinterface

// File: rtl/prog_sequencer_cycle_ctr.sv
// Saturating cycle counter with synchronous clear; tc flags the count that
// lands on TIMEOUT so the caller can stop on exactly that value.
module seq_cycle_ctr #(
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = 16'd60000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // Compare the incoming value so the run stops with count == TIMEOUT, not one past it.
  assign tc_o    = en_i && (count_d == TIMEOUT);

endmodule

// File: rtl/prog_sequencer.sv
// Run controller: each req rise launches the next program round-robin, runs
// the core until halt or watchdog, then holds ack.
//   state | meaning
//   IDLE  | waiting for first request after reset
//   LOAD  | one-cycle pc_load of next program's start address
//   RUN   | core enabled, counting cycles, watching halt and watchdog
//   DONE  | run finished (halt or fault), ack held until next request
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int               PC_W    = 10,
  parameter logic [PC_W-1:0]  START1  = 10'd0,
  parameter logic [PC_W-1:0]  START2  = 10'd256,
  parameter logic [PC_W-1:0]  START3  = 10'd512,
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = 16'd60000
) (
  input  logic              clk,
  input  logic              reset,
  prog_sequencer_if.slave   bus
);

  seq_state_t       state_q, state_d;
  prog_id_t         prog_id_q, prog_id_d;
  prog_id_t         next_q, next_d;
  logic             fault_q, fault_d;
  logic             req_q;
  logic             rise;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt;
  logic [PC_W-1:0]  start_sel;

  assign rise = bus.req & ~req_q;

  always_comb begin
    state_d   = state_q;
    prog_id_d = prog_id_q;
    next_d    = next_q;
    fault_d   = fault_q;
    case (state_q)
      IDLE: if (rise) state_d = LOAD;
      LOAD: begin
        prog_id_d = next_q;
        next_d    = next_prog(next_q);
        fault_d   = 1'b0;
        state_d   = RUN;
      end
      // halt has priority over a watchdog hit in the same cycle
      RUN: begin
        if (bus.halt) begin
          state_d = DONE;
        end else if (cnt_tc) begin
          state_d = DONE;
          fault_d = 1'b1;
        end
      end
      DONE: if (rise) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      prog_id_q <= 2'd0;
      next_q    <= 2'd1;
      fault_q   <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prog_id_q <= prog_id_d;
      next_q    <= next_d;
      fault_q   <= fault_d;
      req_q     <= bus.req;
    end
  end

  seq_cycle_ctr #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_cycle_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (state_q == LOAD),
    .en_i    (state_q == RUN),
    .count_o (cnt),
    .tc_o    (cnt_tc)
  );

  always_comb begin
    case (next_q)
      2'd2:    start_sel = START2;
      2'd3:    start_sel = START3;
      default: start_sel = START1;
    endcase
  end

  assign bus.pc_load   = (state_q == LOAD);
  assign bus.start_pc  = (state_q == LOAD) ? start_sel : '0;
  assign bus.run_en    = (state_q == RUN);
  assign bus.ack       = (state_q == DONE);
  assign bus.prog_id   = prog_id_q;
  assign bus.cycle_cnt = cnt;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a small halt-generating core model.
module tb_prog_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   halt_dly = 0;
  int   hcnt     = 0;
  bit   armed    = 1'b0;

  prog_sequencer_if #(.PC_W(10), .CNT_W(16)) bus ();

  prog_sequencer #(.TIMEOUT(16'd100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Core model: halt rises halt_dly cycles after the pc_load cycle and is
  // cleared one cycle after pc_load, as the core clears it on the load edge.
  always @(negedge clk) begin
    if (reset) begin
      bus.halt = 1'b0;
      hcnt     = 0;
      armed    = 1'b0;
    end else if (bus.pc_load) begin
      hcnt  = 0;
      armed = 1'b1;
    end else begin
      hcnt++;
      if (hcnt == 1) bus.halt = 1'b0;
      if (armed && halt_dly != 0 && hcnt == halt_dly) begin
        bus.halt = 1'b1;
        armed    = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input string tag, input int exp_start, input int exp_id,
                        input bit hold, input int pulse_at, input int hdly,
                        input int exp_cnt, input bit exp_fault, input int exp_lat);
    int n;
    halt_dly = hdly;
    bus.req  = 1'b1;
    tick();
    chk({tag, ".pc_load"},  32'(bus.pc_load),  32'd1);
    chk({tag, ".start_pc"}, 32'(bus.start_pc), 32'(exp_start));
    chk({tag, ".ack_load"}, 32'(bus.ack),      32'd0);
    if (!hold) bus.req = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        chk({tag, ".run_en"},    32'(bus.run_en),    32'd1);
        chk({tag, ".fault_clr"}, 32'(bus.fault),     32'd0);
        chk({tag, ".cnt_clr"},   32'(bus.cycle_cnt), 32'd0);
      end
      if (hold) bus.req = 1'b1;
      else      bus.req = (pulse_at != 0 && n == pulse_at);
    end while (!bus.ack && n < 300);
    if (!hold) bus.req = 1'b0;
    chk({tag, ".latency"},   32'(n),             32'(exp_lat));
    chk({tag, ".prog_id"},   32'(bus.prog_id),   32'(exp_id));
    chk({tag, ".cycle_cnt"}, 32'(bus.cycle_cnt), 32'(exp_cnt));
    chk({tag, ".fault"},     32'(bus.fault),     32'(exp_fault));
    chk({tag, ".run_en_off"}, 32'(bus.run_en),   32'd0);
  endtask

  initial begin
    int loads;
    bus.req = 1'b0;
    reset   = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst.ack",       32'(bus.ack),       32'd0);
    chk("rst.run_en",    32'(bus.run_en),    32'd0);
    chk("rst.prog_id",   32'(bus.prog_id),   32'd0);
    chk("rst.cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
    chk("rst.fault",     32'(bus.fault),     32'd0);
    loads = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.pc_load) loads++;
    end
    chk("idle.no_pc_load", 32'(loads), 32'd0);

    launch("run1", 0,   1, 1'b0, 0, 50, 50, 1'b0, 51);
    tick(); tick();
    chk("run1.ack_held", 32'(bus.ack), 32'd1);
    launch("run2", 256, 2, 1'b0, 0, 50, 50, 1'b0, 51);
    launch("run3", 512, 3, 1'b0, 0, 50, 50, 1'b0, 51);
    launch("run4", 0,   1, 1'b0, 0, 50, 50, 1'b0, 51);

    // req held across the run and well past DONE
    launch("held", 256, 2, 1'b1, 0, 50, 50, 1'b0, 51);
    loads = 0;
    for (int i = 0; i < 148; i++) begin
      tick();
      if (bus.pc_load) loads++;
    end
    chk("held.no_relaunch", 32'(loads),   32'd0);
    chk("held.ack",         32'(bus.ack), 32'd1);
    bus.req = 1'b0;
    tick(); tick();
    chk("held.ack_after_drop", 32'(bus.ack), 32'd1);

    // extra rise during RUN is dropped, not queued
    launch("pulse", 512, 3, 1'b0, 10, 50, 50, 1'b0, 51);
    loads = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.pc_load) loads++;
    end
    chk("pulse.not_queued", 32'(loads), 32'd0);

    launch("tmo",       0,   1, 1'b0, 0, 0,  100, 1'b1, 101);
    launch("after_tmo", 256, 2, 1'b0, 0, 50, 50,  1'b0, 51);

    // reset 10 cycles into RUN
    halt_dly = 50;
    bus.req  = 1'b1;
    tick();
    chk("rstrun.pc_load",  32'(bus.pc_load),  32'd1);
    chk("rstrun.start_pc", 32'(bus.start_pc), 32'd512);
    bus.req = 1'b0;
    repeat (10) tick();
    chk("rstrun.running", 32'(bus.run_en), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstrun.run_en",    32'(bus.run_en),    32'd0);
    chk("rstrun.state",     32'(dut.state_q),   32'd0);
    chk("rstrun.ack",       32'(bus.ack),       32'd0);
    chk("rstrun.prog_id",   32'(bus.prog_id),   32'd0);
    chk("rstrun.cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
    loads = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ack) loads++;
    end
    chk("rstrun.no_ack", 32'(loads), 32'd0);
    launch("post_rst", 0, 1, 1'b0, 0, 50, 50, 1'b0, 51);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
